// File: rtl/or_fifo_dut.sv
`default_nettype none
// ============================================================================
//  Module      : or_fifo_q / or_fifo_dut
//  Description : Register-mapped OR test block. Two 1-bit operand FIFOs (A, B)
//                feed an OR stage whose results are queued in a 1-bit result
//                FIFO (Y). Operands are written through a write port; status
//                and results are read through a combinational read port.
//  Ports (or_fifo_dut):
//    CLK           in   rising-edge clock
//    RST_N         in   asynchronous reset, active HIGH (1 = reset)
//    write_address in 3 4 = FIFO A, 5 = FIFO B, others ignored
//    write_data    in 1 operand bit
//    write_en      in 1 write strobe
//    write_rdy     out  1 once out of reset, 0 while in reset
//    read_address  in 3 0 = A not-full, 1 = B not-full, 2 = Y not-empty,
//                       3 = Y data, others read 0
//    read_en       in 1 pops Y when read_address = 3
//    read_data     out  combinational read result
//    read_rdy      out  1 once out of reset, 0 while in reset
//  Revision    : 1.0  initial release
// ============================================================================

// ----------------------------------------------------------------------------
// Single-bit FIFO. The caller is responsible for gating push/pop against
// full/empty, which lets the result FIFO accept a push while full when the
// same edge pops it.
// ----------------------------------------------------------------------------
module or_fifo_q #(
    parameter int DEPTH = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic push,
    input  logic push_data,
    input  logic pop,
    output logic head,
    output logic empty,
    output logic full
);
    // Pointer is at least one bit wide; storage is rounded up to a power of
    // two so the pointer always indexes in range (extra slots are unused).
    localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW    = $clog2(DEPTH + 1);
    localparam int SLOTS = 1 << PW;

    localparam logic [PW-1:0] c_last_ptr = PW'(DEPTH - 1);
    localparam logic [CW-1:0] c_depth    = CW'(DEPTH);

    logic [SLOTS-1:0] r_mem;
    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;

    logic [PW-1:0]    w_wr_next;
    logic [PW-1:0]    w_rd_next;

    assign w_wr_next = (r_wr_ptr == c_last_ptr) ? '0 : r_wr_ptr + PW'(1);
    assign w_rd_next = (r_rd_ptr == c_last_ptr) ? '0 : r_rd_ptr + PW'(1);

    assign head  = r_mem[r_rd_ptr];
    assign empty = (r_count == '0);
    assign full  = (r_count == c_depth);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mem    <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (push) begin
                r_mem[r_wr_ptr] <= push_data;
                r_wr_ptr        <= w_wr_next;
            end
            if (pop) begin
                r_rd_ptr <= w_rd_next;
            end
            case ({push, pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end
endmodule

module or_fifo_dut #(
    parameter int A_DEPTH = 2,
    parameter int B_DEPTH = 2,
    parameter int Y_DEPTH = 1
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic [2:0] write_address,
    input  logic       write_data,
    input  logic       write_en,
    output logic       write_rdy,
    input  logic [2:0] read_address,
    input  logic       read_en,
    output logic       read_data,
    output logic       read_rdy
);
    localparam logic [2:0] c_addr_a      = 3'd4;
    localparam logic [2:0] c_addr_b      = 3'd5;
    localparam logic [2:0] c_addr_a_nf   = 3'd0;
    localparam logic [2:0] c_addr_b_nf   = 3'd1;
    localparam logic [2:0] c_addr_y_ne   = 3'd2;
    localparam logic [2:0] c_addr_y_data = 3'd3;

    logic r_ready;
    logic w_a_head, w_a_empty, w_a_full;
    logic w_b_head, w_b_empty, w_b_full;
    logic w_y_head, w_y_empty, w_y_full;
    logic w_a_push, w_b_push, w_y_pop, w_fire;

    // Ready drops asynchronously with reset and returns on the first edge
    // after release.
    always_ff @(posedge CLK or posedge RST_N) begin
        if (RST_N) begin
            r_ready <= 1'b0;
        end else begin
            r_ready <= 1'b1;
        end
    end

    assign write_rdy = r_ready;
    assign read_rdy  = r_ready;

    // Writes to a full operand FIFO are dropped, even if the OR stage pops
    // that FIFO on the same edge.
    assign w_a_push = write_en && (write_address == c_addr_a) && !w_a_full;
    assign w_b_push = write_en && (write_address == c_addr_b) && !w_b_full;
    assign w_y_pop  = read_en && (read_address == c_addr_y_data) && !w_y_empty;

    // Y has room if not full, or if the host is draining it this same edge.
    assign w_fire = !w_a_empty && !w_b_empty && (!w_y_full || w_y_pop);

    or_fifo_q #(.DEPTH(A_DEPTH)) u_fifo_a (
        .clk       (CLK),
        .rst       (RST_N),
        .push      (w_a_push),
        .push_data (write_data),
        .pop       (w_fire),
        .head      (w_a_head),
        .empty     (w_a_empty),
        .full      (w_a_full)
    );

    or_fifo_q #(.DEPTH(B_DEPTH)) u_fifo_b (
        .clk       (CLK),
        .rst       (RST_N),
        .push      (w_b_push),
        .push_data (write_data),
        .pop       (w_fire),
        .head      (w_b_head),
        .empty     (w_b_empty),
        .full      (w_b_full)
    );

    or_fifo_q #(.DEPTH(Y_DEPTH)) u_fifo_y (
        .clk       (CLK),
        .rst       (RST_N),
        .push      (w_fire),
        .push_data (w_a_head | w_b_head),
        .pop       (w_y_pop),
        .head      (w_y_head),
        .empty     (w_y_empty),
        .full      (w_y_full)
    );

    always_comb begin
        read_data = 1'b0;
        case (read_address)
            c_addr_a_nf:   read_data = !w_a_full;
            c_addr_b_nf:   read_data = !w_b_full;
            c_addr_y_ne:   read_data = !w_y_empty;
            c_addr_y_data: read_data = w_y_empty ? 1'b0 : w_y_head;
            default:       read_data = 1'b0;
        endcase
    end
endmodule

`default_nettype wire

// File: tb/tb_or_fifo_dut.sv
`default_nettype none
// ============================================================================
//  Module      : tb_or_fifo_dut
//  Description : Directed self-checking bench for or_fifo_dut.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_or_fifo_dut;
    logic       CLK = 1'b0;
    logic       RST_N = 1'b1;
    logic [2:0] write_address = 3'd0;
    logic       write_data = 1'b0;
    logic       write_en = 1'b0;
    logic       write_rdy;
    logic [2:0] read_address = 3'd0;
    logic       read_en = 1'b0;
    logic       read_data;
    logic       read_rdy;

    int vectors = 0;
    int miscompares = 0;

    always #5 CLK = ~CLK;

    or_fifo_dut dut (
        .CLK           (CLK),
        .RST_N         (RST_N),
        .write_address (write_address),
        .write_data    (write_data),
        .write_en      (write_en),
        .write_rdy     (write_rdy),
        .read_address  (read_address),
        .read_en       (read_en),
        .read_data     (read_data),
        .read_rdy      (read_rdy)
    );

    // ---------------- stimulus helpers (no checking here) ----------------
    task automatic do_write(input logic [2:0] a, input logic d);
        @(negedge CLK);
        write_address = a;
        write_data    = d;
        write_en      = 1'b1;
        @(posedge CLK);
        #1 write_en = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic peek(input logic [2:0] a, output logic d);
        read_address = a;
        #1 d = read_data;
    endtask

    task automatic pop_y();
        @(negedge CLK);
        read_address = 3'd3;
        read_en      = 1'b1;
        @(posedge CLK);
        #1 read_en = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge CLK);
        RST_N = 1'b1;
        @(negedge CLK);
        RST_N = 1'b0;
        idle(1);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        logic d;
        logic exp_st [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
        RST_N = 1'b1;
        #12;
        for (int i = 0; i < 4; i++) begin
            peek(3'(i), d);
            vectors++;
            if (d !== exp_st[i]) begin
                miscompares++;
                $display("FAIL reset_status[%0d] got %b want %b", i, d, exp_st[i]);
            end
        end
        vectors++;
        if (write_rdy !== 1'b0 || read_rdy !== 1'b0) begin
            miscompares++;
            $display("FAIL rdy_in_reset got w=%b r=%b want 0 0", write_rdy, read_rdy);
        end
        @(negedge CLK);
        RST_N = 1'b0;
        idle(1);
        vectors++;
        if (write_rdy !== 1'b1 || read_rdy !== 1'b1) begin
            miscompares++;
            $display("FAIL rdy_after_reset got w=%b r=%b want 1 1", write_rdy, read_rdy);
        end
    endtask

    task automatic test_basic();
        logic d;
        do_reset();
        do_write(3'd4, 1'b1);
        do_write(3'd5, 1'b0);
        peek(3'd2, d);
        vectors++;
        if (d !== 1'b0) begin
            miscompares++;
            $display("FAIL basic_latency got %b want 0", d);
        end
        idle(1);
        peek(3'd2, d);
        vectors++;
        if (d !== 1'b1) begin
            miscompares++;
            $display("FAIL basic_y_valid got %b want 1", d);
        end
        peek(3'd3, d);
        vectors++;
        if (d !== 1'b1) begin
            miscompares++;
            $display("FAIL basic_y_data got %b want 1", d);
        end
        pop_y();
        peek(3'd2, d);
        vectors++;
        if (d !== 1'b0) begin
            miscompares++;
            $display("FAIL basic_after_pop got %b want 0", d);
        end
    endtask

    task automatic test_full_drop();
        logic d;
        do_reset();
        do_write(3'd4, 1'b1);
        do_write(3'd4, 1'b0);
        peek(3'd0, d);
        vectors++;
        if (d !== 1'b0) begin
            miscompares++;
            $display("FAIL a_full_status got %b want 0", d);
        end
        do_write(3'd4, 1'b1);   // dropped: A full
        do_write(3'd5, 1'b0);
        idle(1);
        peek(3'd3, d);
        vectors++;
        if (d !== 1'b1) begin
            miscompares++;
            $display("FAIL drop_first_result got %b want 1", d);
        end
        pop_y();
        do_write(3'd5, 1'b0);
        idle(1);
        peek(3'd2, d);
        vectors++;
        if (d !== 1'b1) begin
            miscompares++;
            $display("FAIL drop_second_valid got %b want 1", d);
        end
        peek(3'd3, d);
        vectors++;
        if (d !== 1'b0) begin
            miscompares++;
            $display("FAIL drop_second_result got %b want 0", d);
        end
        pop_y();
        // If the third write had been kept, this B operand would fire.
        do_write(3'd5, 1'b0);
        idle(2);
        peek(3'd2, d);
        vectors++;
        if (d !== 1'b0) begin
            miscompares++;
            $display("FAIL drop_a_empty got %b want 0", d);
        end
    endtask

    task automatic test_pairs();
        logic d;
        logic pa  [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
        logic pb  [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
        logic exp [4] = '{1'b0, 1'b1, 1'b1, 1'b1};
        do_reset();
        for (int i = 0; i < 4; i++) begin
            do_write(3'd4, pa[i]);
            do_write(3'd5, pb[i]);
            idle(1);
            peek(3'd2, d);
            vectors++;
            if (d !== 1'b1) begin
                miscompares++;
                $display("FAIL pair%0d_valid got %b want 1", i, d);
            end
            peek(3'd3, d);
            vectors++;
            if (d !== exp[i]) begin
                miscompares++;
                $display("FAIL pair%0d_data got %b want %b", i, d, exp[i]);
            end
            pop_y();
        end
    endtask

    task automatic test_back_to_back();
        logic d;
        logic exp_st [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
        do_reset();
        do_write(3'd4, 1'b1);
        do_write(3'd5, 1'b0);   // Y <- 1
        do_write(3'd4, 1'b0);
        do_write(3'd4, 1'b0);
        do_write(3'd5, 1'b0);   // pair (0,0) -> 0, held back
        do_write(3'd5, 1'b1);   // pair (0,1) -> 1, held back
        idle(2);
        for (int i = 0; i < 4; i++) begin
            peek(3'(i), d);
            vectors++;
            if (d !== exp_st[i]) begin
                miscompares++;
                $display("FAIL b2b_held[%0d] got %b want %b", i, d, exp_st[i]);
            end
        end
        pop_y();
        peek(3'd3, d);
        vectors++;
        if (d !== 1'b0) begin
            miscompares++;
            $display("FAIL b2b_second got %b want 0", d);
        end
        peek(3'd2, d);
        vectors++;
        if (d !== 1'b1) begin
            miscompares++;
            $display("FAIL b2b_second_valid got %b want 1", d);
        end
        peek(3'd0, d);
        vectors++;
        if (d !== 1'b1) begin
            miscompares++;
            $display("FAIL b2b_a_room got %b want 1", d);
        end
        pop_y();
        peek(3'd3, d);
        vectors++;
        if (d !== 1'b1) begin
            miscompares++;
            $display("FAIL b2b_third got %b want 1", d);
        end
        pop_y();
        peek(3'd2, d);
        vectors++;
        if (d !== 1'b0) begin
            miscompares++;
            $display("FAIL b2b_drained got %b want 0", d);
        end
    endtask

    task automatic test_reset_mid();
        logic d;
        logic exp_st [8] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        do_reset();
        do_write(3'd4, 1'b1);
        do_write(3'd5, 1'b1);
        do_write(3'd4, 1'b0);
        do_write(3'd4, 1'b0);
        do_write(3'd5, 1'b1);
        idle(1);
        peek(3'd0, d);
        vectors++;
        if (d !== 1'b0) begin
            miscompares++;
            $display("FAIL mid_pre_a got %b want 0", d);
        end
        // Assert reset between edges; status must clear without a clock.
        #2 RST_N = 1'b1;
        for (int i = 0; i < 4; i++) begin
            peek(3'(i), d);
            vectors++;
            if (d !== exp_st[i]) begin
                miscompares++;
                $display("FAIL mid_reset[%0d] got %b want %b", i, d, exp_st[i]);
            end
        end
        @(negedge CLK);
        RST_N = 1'b0;
        idle(1);
        do_write(3'd6, 1'b1);
        do_write(3'd7, 1'b1);
        @(negedge CLK);
        read_address = 3'd7;
        read_en      = 1'b1;
        idle(1);
        read_en = 1'b0;
        idle(2);
        for (int i = 0; i < 8; i++) begin
            peek(3'(i), d);
            vectors++;
            if (d !== exp_st[i]) begin
                miscompares++;
                $display("FAIL ignored_addr[%0d] got %b want %b", i, d, exp_st[i]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_full_drop();
        test_pairs();
        test_back_to_back();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

`default_nettype wire
